// File: rtl/pll_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_supervisor_pkg
// Description : Shared state encodings and helpers for the PLL lock supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_supervisor_pkg;

    localparam int STATE_W = 3;

    // Encodings are visible on the STATE debug port, so keep them stable.
    typedef enum logic [STATE_W-1:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_FILTER    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    // Largest of four values; sizes the shared timer.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_supervisor_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchronizer with synchronous active-low reset.
//               Generic; used here to bring PLL LOCK into the reference domain.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; both stages clear to 0 on reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_supervisor
// Description : PLL lock supervisor on the 27 MHz reference clock. Pulses the
//               PLL reset, debounces lock, releases the system reset after a
//               settling delay and restarts the PLL on timeout, lock loss or
//               software request. Counts involuntary relocks (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int PLL_RESET_CYCLES = 8,      // must be >= 2
    parameter int LOCK_FILTER      = 16,
    parameter int RELEASE_DELAY    = 1024,
    parameter int LOCK_TIMEOUT     = 270000
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               LOCK,
    input  logic               REQ_RELOCK,
    output logic               PLL_RESET,
    output logic               SYS_RESETN,
    output logic [7:0]         RELOCK_COUNT,
    output logic [STATE_W-1:0] STATE
);

    localparam int TIMER_MAX = max4(PLL_RESET_CYCLES, LOCK_FILTER, RELEASE_DELAY, LOCK_TIMEOUT);
    localparam int TIMER_W   = $clog2(TIMER_MAX) + 1;

    // Terminal timer values. The timer reads 0 on the first edge after entry,
    // so "N cycles in state" ends when it reads N-1. The reset-pulse state is
    // measured from the reset edge itself, which makes its end one later.
    localparam logic [TIMER_W-1:0] C_T_RESET   = TIMER_W'(PLL_RESET_CYCLES);
    localparam logic [TIMER_W-1:0] C_T_TIMEOUT = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] C_T_FILTER  = TIMER_W'(LOCK_FILTER - 1);
    localparam logic [TIMER_W-1:0] C_T_RELEASE = TIMER_W'(RELEASE_DELAY - 1);
    localparam logic [TIMER_W-1:0] C_T_SAT     = {TIMER_W{1'b1}};

    state_t             r_state;
    state_t             w_next;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_next;
    logic [7:0]         r_count;
    logic               r_pll_reset;
    logic               r_sys_resetn;
    logic               w_lock_s;
    logic               w_lock_event;
    logic               w_count_inc;

    sync_2ff u_lock_sync (
        .i_clk   (CLK),
        .i_rst_n (RESETN),
        .i_d     (LOCK),
        .o_q     (w_lock_s)
    );

    // Next-state, timer and relock-count decisions; lock events outrank REQ_RELOCK.
    always_comb begin
        w_next       = r_state;
        w_lock_event = 1'b0;
        w_count_inc  = 1'b0;
        w_timer_next = r_timer;

        case (r_state)
            S_RESET_PLL: begin
                if (r_timer == C_T_RESET) w_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next = S_FILTER;
                end else if (r_timer == C_T_TIMEOUT) begin
                    w_next       = S_RESET_PLL;
                    w_lock_event = 1'b1;
                    w_count_inc  = 1'b1;
                end
            end
            S_FILTER: begin
                if (!w_lock_s) begin
                    // Bounce during debounce: retry the wait, not counted.
                    w_next       = S_WAIT_LOCK;
                    w_lock_event = 1'b1;
                end else if (r_timer == C_T_FILTER) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_lock_s) begin
                    w_next       = S_RESET_PLL;
                    w_lock_event = 1'b1;
                    w_count_inc  = 1'b1;
                end else if (r_timer == C_T_RELEASE) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_next       = S_RESET_PLL;
                    w_lock_event = 1'b1;
                    w_count_inc  = 1'b1;
                end
            end
            default: begin
                w_next = S_RESET_PLL;
            end
        endcase

        if (REQ_RELOCK && (r_state != S_RESET_PLL) && !w_lock_event) begin
            w_next = S_RESET_PLL;
        end

        if (w_next != r_state) begin
            w_timer_next = '0;
        end else if (r_timer != C_T_SAT) begin
            w_timer_next = r_timer + TIMER_W'(1);
        end
    end

    // State, timer, counter and outputs all register on the same edge.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state      <= S_RESET_PLL;
            r_timer      <= '0;
            r_count      <= 8'd0;
            r_pll_reset  <= 1'b1;
            r_sys_resetn <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_timer      <= w_timer_next;
            r_pll_reset  <= (w_next == S_RESET_PLL);
            r_sys_resetn <= (w_next == S_RUN);
            if (w_count_inc && (r_count != 8'hFF)) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign PLL_RESET    = r_pll_reset;
    assign SYS_RESETN   = r_sys_resetn;
    assign RELOCK_COUNT = r_count;
    assign STATE        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_supervisor
// Description : Self-checking bench for pll_supervisor. Expected timing is
//               derived from the lock-sequence arithmetic: with E the edge on
//               which the PLL reset phase is entered (E = -1 for RESETN),
//               PLL_RESET falls at E+PRC+1, SYS_RESETN rises at
//               E+PRC+2+LF+RD, and a missing lock times out at E+PRC+1+LT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_supervisor;

    localparam int PRC = 4;
    localparam int LF  = 8;
    localparam int RD  = 32;
    localparam int LT  = 100;

    localparam int FALL_AFTER_ENTRY    = PRC + 1;
    localparam int RUN_AFTER_ENTRY     = PRC + 2 + LF + RD;
    localparam int TIMEOUT_AFTER_ENTRY = PRC + 1 + LT;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       lock = 1'b0;
    logic       req  = 1'b0;
    wire        pll_reset;
    wire        sys_resetn;
    wire  [7:0] cnt;
    wire  [2:0] st;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = -1;   // index of the last clock edge
    int model_cnt = 0;

    always #5 clk = ~clk;

    pll_supervisor #(
        .PLL_RESET_CYCLES (PRC),
        .LOCK_FILTER      (LF),
        .RELEASE_DELAY    (RD),
        .LOCK_TIMEOUT     (LT)
    ) dut (
        .CLK          (clk),
        .RESETN       (rstn),
        .LOCK         (lock),
        .REQ_RELOCK   (req),
        .PLL_RESET    (pll_reset),
        .SYS_RESETN   (sys_resetn),
        .RELOCK_COUNT (cnt),
        .STATE        (st)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    // Holds reset for a few edges; the next edge is edge 0.
    task automatic apply_reset(input logic lock_val);
        rstn = 1'b0;
        req  = 1'b0;
        lock = lock_val;
        tick_n(3);
        rstn      = 1'b1;
        e         = -1;
        model_cnt = 0;
    endtask

    task automatic test_reset();
        lock = 1'b1;
        rstn = 1'b0;
        tick_n(2);
        n_checks++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset); end
        n_checks++; if (sys_resetn !== 1'b0) begin n_fail++; $display("FAIL reset_sys_resetn: got %b want 0", sys_resetn); end
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt); end
        n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st); end
    endtask

    task automatic test_lock_high();
        logic exp_pll, exp_sys;
        apply_reset(1'b1);
        for (int i = 0; i <= RUN_AFTER_ENTRY + 3; i++) begin
            tick();
            exp_pll = (e < -1 + FALL_AFTER_ENTRY);
            exp_sys = (e >= -1 + RUN_AFTER_ENTRY);
            n_checks++; if (pll_reset !== exp_pll) begin n_fail++; $display("FAIL lock_high_pll_reset edge %0d: got %b want %b", e, pll_reset, exp_pll); end
            n_checks++; if (sys_resetn !== exp_sys) begin n_fail++; $display("FAIL lock_high_sys_resetn edge %0d: got %b want %b", e, sys_resetn, exp_sys); end
        end
        n_checks++; if (st !== 3'd4) begin n_fail++; $display("FAIL lock_high_state: got %0d want 4", st); end
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL lock_high_count: got %0d want 0", cnt); end
    endtask

    task automatic test_lock_low();
        int exp_st;
        int w;
        apply_reset(1'b0);
        for (int i = 0; i <= TIMEOUT_AFTER_ENTRY - 1; i++) begin
            tick();
            if (e < -1 + FALL_AFTER_ENTRY)         exp_st = 0;
            else if (e < -1 + TIMEOUT_AFTER_ENTRY) exp_st = 1;
            else                                   exp_st = 0;
            n_checks++; if (st !== 3'(exp_st)) begin n_fail++; $display("FAIL lock_low_state edge %0d: got %0d want %0d", e, st, exp_st); end
        end
        n_checks++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL lock_low_first_timeout_count: got %0d want 1", cnt); end
        n_checks++; if (sys_resetn !== 1'b0) begin n_fail++; $display("FAIL lock_low_sys_resetn: got %b want 0", sys_resetn); end
        // Every further timeout adds one until the counter saturates.
        w = 0;
        while (cnt !== 8'd255 && w < 300 * TIMEOUT_AFTER_ENTRY) begin
            tick();
            w++;
        end
        n_checks++; if (cnt !== 8'd255) begin n_fail++; $display("FAIL lock_low_reach_255: got %0d want 255 after %0d cycles", cnt, w); end
        tick_n(3 * TIMEOUT_AFTER_ENTRY);
        n_checks++; if (cnt !== 8'd255) begin n_fail++; $display("FAIL lock_low_saturate: got %0d want 255", cnt); end
    endtask

    task automatic test_filter_glitch();
        int j, g;
        for (int t = 0; t < 3; t++) begin
            apply_reset(1'b0);
            j = $urandom_range(4, 60);
            g = (t == 0) ? 5 : $urandom_range(1, LF - 1);
            while (e < j + g + 103) begin
                tick();
                if (e == j)     lock = 1'b1;
                if (e == j + g) lock = 1'b0;
                if (e == j + 3) begin
                    n_checks++; if (st !== 3'd2) begin n_fail++; $display("FAIL glitch_enter_filter j=%0d g=%0d: got %0d want 2", j, g, st); end
                end
                if (e == j + g + 3) begin
                    n_checks++; if (st !== 3'd1) begin n_fail++; $display("FAIL glitch_back_to_wait j=%0d g=%0d: got %0d want 1", j, g, st); end
                    n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", cnt); end
                    n_checks++; if (sys_resetn !== 1'b0) begin n_fail++; $display("FAIL glitch_sys_resetn: got %b want 0", sys_resetn); end
                end
                if (e == j + g + 102) begin
                    n_checks++; if (st !== 3'd1) begin n_fail++; $display("FAIL glitch_timeout_restart_early j=%0d g=%0d: got %0d want 1", j, g, st); end
                end
            end
            n_checks++; if (st !== 3'd0 || cnt !== 8'd1) begin n_fail++; $display("FAIL glitch_timeout_restart: got state %0d count %0d want 0/1", st, cnt); end
        end
    endtask

    // Follows a relock entered at edge ent with LOCK high, through to S_RUN.
    task automatic check_recovery(input int ent, input string tag);
        while (e < ent + RUN_AFTER_ENTRY) begin
            tick();
            if (e == ent + FALL_AFTER_ENTRY - 1) begin
                n_checks++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL %s_pll_before_fall: got %b want 1", tag, pll_reset); end
            end
            if (e == ent + FALL_AFTER_ENTRY) begin
                n_checks++; if (pll_reset !== 1'b0) begin n_fail++; $display("FAIL %s_pll_fall: got %b want 0", tag, pll_reset); end
            end
            if (e == ent + RUN_AFTER_ENTRY - 1) begin
                n_checks++; if (sys_resetn !== 1'b0) begin n_fail++; $display("FAIL %s_sys_before_rise: got %b want 0", tag, sys_resetn); end
            end
        end
        n_checks++; if (sys_resetn !== 1'b1) begin n_fail++; $display("FAIL %s_sys_rise: got %b want 1", tag, sys_resetn); end
    endtask

    task automatic test_lock_loss_run();
        int j;
        apply_reset(1'b1);
        tick_n(RUN_AFTER_ENTRY);
        tick_n($urandom_range(0, 20));
        j = e;
        lock = 1'b0;
        tick_n(2);
        n_checks++; if (sys_resetn !== 1'b1) begin n_fail++; $display("FAIL loss_sys_still_high: got %b want 1", sys_resetn); end
        tick();
        model_cnt++;
        lock = 1'b1;
        n_checks++; if (sys_resetn !== 1'b0 || pll_reset !== 1'b1) begin n_fail++; $display("FAIL loss_outputs edge %0d: got sys %b pll %b want 0/1", e, sys_resetn, pll_reset); end
        n_checks++; if (cnt !== 8'(model_cnt)) begin n_fail++; $display("FAIL loss_count: got %0d want %0d", cnt, model_cnt); end
        n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL loss_state: got %0d want 0", st); end
        check_recovery(j + 3, "loss_recovery");
    endtask

    task automatic test_req_relock();
        int ent, j;
        tick_n($urandom_range(0, 10));
        req = 1'b1;
        tick();
        req = 1'b0;
        ent = e;
        n_checks++; if (st !== 3'd0 || pll_reset !== 1'b1 || sys_resetn !== 1'b0) begin n_fail++; $display("FAIL req_immediate: got state %0d pll %b sys %b want 0/1/0", st, pll_reset, sys_resetn); end
        n_checks++; if (cnt !== 8'(model_cnt)) begin n_fail++; $display("FAIL req_count: got %0d want %0d", cnt, model_cnt); end
        // A request while already resetting the PLL must not stretch the pulse.
        tick_n(2);
        req = 1'b1;
        tick();
        req = 1'b0;
        check_recovery(ent, "req_recovery");
        // Request in the same cycle that lock loss is seen: counted once.
        tick_n($urandom_range(0, 10));
        j = e;
        lock = 1'b0;
        tick_n(2);
        req = 1'b1;
        tick();
        req  = 1'b0;
        lock = 1'b1;
        model_cnt++;
        n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL req_and_loss_state edge %0d: got %0d want 0", e, st); end
        n_checks++; if (cnt !== 8'(model_cnt)) begin n_fail++; $display("FAIL req_and_loss_count: got %0d want %0d", cnt, model_cnt); end
        tick_n(7);
        n_checks++; if (cnt !== 8'(model_cnt)) begin n_fail++; $display("FAIL req_and_loss_count_once: got %0d want %0d", cnt, model_cnt); end
        check_recovery(j + 3, "req_loss_recovery");
    endtask

    task automatic test_reset_mid_hold();
        int w;
        lock = 1'b0;
        tick_n(3);
        lock = 1'b1;
        model_cnt++;
        w = 0;
        while (st !== 3'd3 && w < 2 * RUN_AFTER_ENTRY) begin
            tick();
            w++;
        end
        n_checks++; if (st !== 3'd3) begin n_fail++; $display("FAIL hold_reached: got %0d want 3 after %0d cycles", st, w); end
        tick_n($urandom_range(1, 20));
        n_checks++; if (cnt !== 8'(model_cnt) || model_cnt != 3) begin n_fail++; $display("FAIL hold_count_before_reset: got %0d want 3", cnt); end
        rstn = 1'b0;
        tick();
        n_checks++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL hold_reset_pll: got %b want 1", pll_reset); end
        n_checks++; if (sys_resetn !== 1'b0) begin n_fail++; $display("FAIL hold_reset_sys: got %b want 0", sys_resetn); end
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL hold_reset_count: got %0d want 0", cnt); end
        n_checks++; if (st !== 3'd0) begin n_fail++; $display("FAIL hold_reset_state: got %0d want 0", st); end
        rstn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock_high();
        test_lock_low();
        test_filter_glitch();
        test_lock_loss_run();
        test_req_relock();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
